capture_ram_arbiter: RTL and testbench
======================================

// Module: capture_ram_arbiter
// PURPOSE
// - Sits between simple_bayer (writer) and the spi register/readout block (reader),
//   sharing one single-port ram_inferred instance.
// - Sequences single-frame capture: arms on request, opens the write path for
//   exactly one fv frame, then drains and reports done.
// - Reader always has priority. Colliding writes are buffered in a small FIFO
//   instead of being dropped, which the bare wr_en & !rd_en gating would do.
// PARAMETERS
// - ADDR        12  RAM address width
// - DATA        30  RAM data width (RGB10 packed)
// - FIFO_DEPTH  4   write-buffer entries; power of 2, >= 2
// PORTS
// - clk           in   1     pixel clock
// - reset_n       in   1     async active-low reset
// - capture_req   in   1     1-cycle pulse: capture the next full frame
// - fv            in   1     frame valid from sensor/image_gen
// - wr_en_in      in   1     write strobe from simple_bayer
// - wr_addr_in    in   ADDR  write address from simple_bayer
// - wr_data_in    in   DATA  rgb10 from simple_bayer
// - rd_en_in      in   1     read strobe from spi
// - rd_addr_in    in   ADDR  read address from spi
// - rd_data_out   out  DATA  read data to spi (1-cycle latency, passes ram_rd_data)
// - ram_wr_en     out  1     RAM write enable
// - ram_wr_addr   out  ADDR  RAM write address
// - ram_wr_data   out  DATA  RAM write data
// - ram_rd_en     out  1     RAM read enable
// - ram_rd_addr   out  ADDR  RAM read address
// - ram_rd_data   in   DATA  RAM read data
// - capture_busy  out  1     high in ARMED/CAPTURE/DRAIN
// - capture_done  out  1     1-cycle pulse on DRAIN->IDLE
// - overflow      out  1     sticky: a write was dropped (FIFO full)
// - pixel_count   out  18    accepted writes in the current/last frame (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: all outputs 0; FSM=IDLE; FIFO empty; fv_d=1, so no false edge
//   if fv is high when reset is released.
// - FSM states: IDLE, ARMED, CAPTURE, DRAIN.
//   - IDLE -> ARMED on capture_req. This also clears overflow and pixel_count.
//   - ARMED -> CAPTURE on fv rising edge (fv & !fv_d).
//   - CAPTURE -> DRAIN on fv falling edge.
//   - DRAIN -> IDLE when the FIFO is empty and no pop is in flight.
//     capture_done pulses in the cycle the FSM enters IDLE.
// - capture_req outside IDLE is ignored; it has no effect on flags.
// - Write acceptance:
//   - A write is pushed into the FIFO only in CAPTURE.
//   - In the fv falling-edge cycle, the write is still accepted.
//   - Writes in any other state are discarded silently (no overflow).
// - RAM port grant, evaluated each cycle:
//   - If rd_en_in: ram_rd_en=1, ram_rd_addr=rd_addr_in, ram_wr_en=0.
//   - Else if the FIFO is non-empty: pop, ram_wr_en=1, drive addr/data from
//     the FIFO head.
//   - Grant outputs are combinational from rd_en_in and FIFO state.
//     Write-to-RAM latency is >= 1 cycle after acceptance.
// - FIFO:
//   - Full with push and no pop in the same cycle: write dropped, overflow<=1.
//   - Full with simultaneous push and pop: push accepted, no overflow.
//   - Empty with simultaneous push and pop: no bypass; data goes in, pop waits.
// - rd_data_out = ram_rd_data. The block never holds the reader off.
// - Address and data pass through unmodified; no range check.
// - Reset mid-capture: FIFO flushed, buffered writes lost, FSM=IDLE.
// CONFIGURATION
// - CAPTURE_ARB_PIXEL_COUNT_EN defined:
//   - pixel_count increments by 1 per accepted FIFO push.
//   - It saturates at 2^18-1 and holds after done until the next capture_req.
// - Not defined: pixel_count tied to 0; counter logic omitted.
// TESTING
// - Reset, fv held high across reset release, capture_req -> FSM stays ARMED
//   until fv falls then rises; no writes accepted before that rise.
// - 1280x4 frame, no reads -> exactly 5120 RAM writes in address order;
//   capture_done pulses once; overflow=0; pixel_count=5120 (macro on).
// - rd_en_in held for 3 cycles while writing 1 pixel/cycle, FIFO_DEPTH=4 ->
//   all reads granted same-cycle; 3 writes buffered; no drop; order preserved.
// - rd_en_in held for 6 cycles under the same traffic -> one write dropped per
//   cycle beyond capacity; overflow=1, sticky until the next capture_req.
// - capture_req during CAPTURE; writes with the FSM in IDLE -> ignored;
//   no RAM writes; flags unchanged.
// - reset_n low mid-frame with 2 FIFO entries -> no further ram_wr_en;
//   all outputs 0 next cycle.

Source files
------------

// File: rtl/capture_ram_arbiter.sv
// Single-frame capture sequencer and single-port RAM arbiter (reader priority, write FIFO).
// Optional pixel counter enabled by defining CAPTURE_ARB_PIXEL_COUNT_EN.
module capture_ram_arbiter #(
  parameter int ADDR       = 12,
  parameter int DATA       = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            capture_req,
  input  logic            fv,
  input  logic            wr_en_in,
  input  logic [ADDR-1:0] wr_addr_in,
  input  logic [DATA-1:0] wr_data_in,
  input  logic            rd_en_in,
  input  logic [ADDR-1:0] rd_addr_in,
  output logic [DATA-1:0] rd_data_out,
  output logic            ram_wr_en,
  output logic [ADDR-1:0] ram_wr_addr,
  output logic [DATA-1:0] ram_wr_data,
  output logic            ram_rd_en,
  output logic [ADDR-1:0] ram_rd_addr,
  input  logic [DATA-1:0] ram_rd_data,
  output logic            capture_busy,
  output logic            capture_done,
  output logic            overflow,
  output logic [17:0]     pixel_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            fv_d;
  logic            fv_rise, fv_fall;
  logic            arm;
  logic [ADDR-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop, drop;

  assign fv_rise    = fv & ~fv_d;
  assign fv_fall    = ~fv & fv_d;
  assign arm        = (state == IDLE) && capture_req;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // The falling-edge cycle is still CAPTURE, so its write is accepted.
  assign push_req = wr_en_in && (state == CAPTURE);
  assign pop      = !rd_en_in && !fifo_empty;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign rd_data_out  = ram_rd_data;
  assign capture_busy = (state != IDLE);

  always_comb begin
    ram_rd_en   = rd_en_in;
    ram_rd_addr = rd_en_in ? rd_addr_in : '0;
    ram_wr_en   = pop;
    ram_wr_addr = pop ? fifo_addr[rd_ptr] : '0;
    ram_wr_data = pop ? fifo_data[rd_ptr] : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_req) state_nxt = ARMED;
      ARMED:   if (fv_rise)     state_nxt = CAPTURE;
      CAPTURE: if (fv_fall)     state_nxt = DRAIN;
      DRAIN:   if (fifo_empty)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // fv_d resets high so a frame already in progress at reset release is not seen as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fv_d         <= 1'b1;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      fv_d         <= fv;
      capture_done <= (state == DRAIN) && fifo_empty;
      if (arm)
        overflow <= 1'b0;
      else if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr_in;
      fifo_data[wr_ptr] <= wr_data_in;
    end
  end

`ifdef CAPTURE_ARB_PIXEL_COUNT_EN
  logic [17:0] pix_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pix_cnt <= '0;
    else if (arm)
      pix_cnt <= '0;
    else if (push && (pix_cnt != '1))
      pix_cnt <= pix_cnt + 18'd1;
  end

  assign pixel_count = pix_cnt;
`else
  assign pixel_count = '0;
`endif

endmodule

// File: tb/tb_capture_ram_arbiter.sv
// Directed bench for capture_ram_arbiter: capture sequencing, reader priority, FIFO overflow, reset.
module tb_capture_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        capture_req, fv, wr_en_in, rd_en_in;
  logic [11:0] wr_addr_in, rd_addr_in;
  logic [29:0] wr_data_in, ram_rd_data;
  logic [29:0] rd_data_out, ram_wr_data;
  logic        ram_wr_en, ram_rd_en;
  logic [11:0] ram_wr_addr, ram_rd_addr;
  logic        capture_busy, capture_done, overflow;
  logic [17:0] pixel_count;

  capture_ram_arbiter #(.ADDR(12), .DATA(30), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .capture_req(capture_req), .fv(fv),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .capture_busy(capture_busy), .capture_done(capture_done),
    .overflow(overflow), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int wr_cnt = 0, order_err = 0, rd_err = 0, done_cnt = 0, acc_cnt = 0;
  logic [41:0] exp_q[$];

  function automatic logic [29:0] mkdata(input int idx);
    return 30'((idx * 7) + 341);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are stable between posedge+1 and the next posedge; observe at negedge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (ram_wr_en === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0 || {ram_wr_addr, ram_wr_data} !== exp_q[0]) order_err++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (capture_done === 1'b1) done_cnt++;
      if (rd_en_in && (ram_rd_en !== 1'b1 || ram_rd_addr !== rd_addr_in || ram_wr_en !== 1'b0))
        rd_err++;
      if (!rd_en_in && ram_rd_en !== 1'b0) rd_err++;
    end
  end

  task automatic step(input logic f, input logic we, input int idx, input logic re, input logic acc);
    fv         = f;
    wr_en_in   = we;
    wr_addr_in = 12'(idx);
    wr_data_in = mkdata(idx);
    rd_en_in   = re;
    rd_addr_in = 12'(idx + 2048);
    if (acc) begin
      exp_q.push_back({12'(idx), mkdata(idx)});
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    capture_req = 1'b0;
  endtask

  task automatic drain_wait();
    for (int k = 0; k < 50 && capture_busy; k++) step(fv, 1'b0, 0, 1'b0, 1'b0);
    check("drain_timeout", capture_busy, 1'b0);
    for (int k = 0; k < 3; k++) step(fv, 1'b0, 0, 1'b0, 1'b0);
  endtask

  int wr_snap, acc_snap, done_snap;
  logic [17:0] pix_snap;

  initial begin
    reset_n = 1'b0; capture_req = 1'b0; fv = 1'b1; wr_en_in = 1'b0; rd_en_in = 1'b0;
    wr_addr_in = '0; rd_addr_in = '0; wr_data_in = '0; ram_rd_data = '0;
    #2;
    check("rst_busy", capture_busy, 1'b0);
    check("rst_done", capture_done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_pix", pixel_count, 18'd0);
    check("rst_wr_en", ram_wr_en, 1'b0);
    check("rst_wr_addr", ram_wr_addr, 12'd0);
    check("rst_rd_en", ram_rd_en, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("idle_after_rst", capture_busy, 1'b0);

    ram_rd_data = 30'h2AAA_5555;
    #1;
    check("rd_data_pass", rd_data_out, 30'h2AAA_5555);
    ram_rd_data = '0;

    // fv high across reset release: stays ARMED, nothing written
    capture_req = 1'b1;
    step(1'b1, 1'b1, 9, 1'b0, 1'b0);
    check("armed_busy", capture_busy, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10 + i, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 20 + i, 1'b0, 1'b0);
    check("armed_hold", capture_busy, 1'b1);
    check("armed_no_wr", wr_cnt, 0);

    // 1280x4 frame, last pixel on the fv falling-edge cycle
    acc_cnt = 0;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5119; i++) step(1'b1, 1'b1, i, 1'b0, 1'b1);
    step(1'b0, 1'b1, 5119, 1'b0, 1'b1);
    drain_wait();
    check("frame_wr_cnt", wr_cnt, 5120);
    check("frame_order", order_err, 0);
    check("frame_done_once", done_cnt, 1);
    check("frame_ovf", overflow, 1'b0);
    check("frame_q_empty", exp_q.size(), 0);
`ifdef CAPTURE_ARB_PIXEL_COUNT_EN
    check("frame_pix", pixel_count, 18'd5120);
`else
    check("frame_pix", pixel_count, 18'd0);
`endif

    // 3 read cycles during 1 pixel/cycle: 3 writes buffered, none dropped
    wr_snap = wr_cnt;
    capture_req = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 256, 1'b0, 1'b1);
    step(1'b1, 1'b1, 257, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 258 + i, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 261 + i, 1'b0, 1'b1);
    step(1'b0, 1'b1, 266, 1'b0, 1'b1);
    drain_wait();
    check("rd3_wr_cnt", wr_cnt - wr_snap, 11);
    check("rd3_order", order_err, 0);
    check("rd3_ovf", overflow, 1'b0);
    check("rd3_done", done_cnt, 2);
    check("rd3_rd_grant", rd_err, 0);
`ifdef CAPTURE_ARB_PIXEL_COUNT_EN
    check("rd3_pix", pixel_count, 18'd11);
`else
    check("rd3_pix", pixel_count, 18'd0);
`endif

    // 6 read cycles: FIFO fills after 3, the next 3 writes are dropped
    wr_snap = wr_cnt;
    capture_req = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 512, 1'b0, 1'b1);
    step(1'b1, 1'b1, 513, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 514 + i, 1'b1, i < 3);
    check("rd6_ovf_set", overflow, 1'b1);
    capture_req = 1'b1;
    step(1'b1, 1'b1, 520, 1'b0, 1'b1);
    check("req_in_capture_ovf", overflow, 1'b1);
    check("req_in_capture_busy", capture_busy, 1'b1);
    step(1'b1, 1'b1, 521, 1'b0, 1'b1);
    step(1'b0, 1'b1, 522, 1'b0, 1'b1);
    drain_wait();
    check("rd6_wr_cnt", wr_cnt - wr_snap, 8);
    check("rd6_order", order_err, 0);
    check("rd6_ovf_sticky", overflow, 1'b1);
    check("rd6_done", done_cnt, 3);
`ifdef CAPTURE_ARB_PIXEL_COUNT_EN
    check("rd6_pix", pixel_count, 18'd8);
`else
    check("rd6_pix", pixel_count, 18'd0);
`endif

    // writes and fv edges while IDLE are ignored
    wr_snap = wr_cnt; done_snap = done_cnt; pix_snap = pixel_count;
    step(1'b1, 1'b1, 600, 1'b0, 1'b0);
    step(1'b0, 1'b1, 601, 1'b0, 1'b0);
    step(1'b1, 1'b1, 602, 1'b0, 1'b0);
    step(1'b1, 1'b1, 603, 1'b0, 1'b0);
    check("idle_no_wr", wr_cnt, wr_snap);
    check("idle_busy", capture_busy, 1'b0);
    check("idle_ovf", overflow, 1'b1);
    check("idle_done", done_cnt, done_snap);
    check("idle_pix", pixel_count, pix_snap);

    capture_req = 1'b1;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("req_clr_ovf", overflow, 1'b0);
    check("req_clr_pix", pixel_count, 18'd0);
    check("req_busy", capture_busy, 1'b1);

    // reset with 2 entries buffered: they are lost
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 700, 1'b0, 1'b1);
    step(1'b1, 1'b1, 701, 1'b1, 1'b1);
    wr_snap = wr_cnt;
    reset_n = 1'b0; wr_en_in = 1'b0; rd_en_in = 1'b0; fv = 1'b1;
    #2;
    check("mid_rst_wr_en", ram_wr_en, 1'b0);
    check("mid_rst_wr_data", ram_wr_data, 30'd0);
    check("mid_rst_busy", capture_busy, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    check("mid_rst_pix", pixel_count, 18'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("post_rst_no_wr", wr_cnt, wr_snap);
    check("post_rst_busy", capture_busy, 1'b0);
    check("post_rst_done", capture_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
